echo_mc: RTL and testbench

ECHO_MC -- requirements
Module: echo_mc

---
 rtl/echo_pkg.sv | 41 ++++
 rtl/echo_dpram.sv | 40 ++++
 rtl/echo_mc.sv | 260 ++++++++++++++++++++++++++
 tb/tb_echo_mc.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// echo_pkg: shared definitions for the multichannel echo block.
//   - default parameter constants used by echo_mc
//   - state_t: frame sequencer states
//   - sat(): clamp a wide signed value into a C_SW-bit two's complement range
package echo_pkg;

  localparam int C_SW_DEF    = 24;
  localparam int C_NCH_DEF   = 2;
  localparam int C_DEPTH_DEF = 4096;
  localparam int C_GW_DEF    = 8;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_RD   = 3'd2,
    S_WT   = 3'd3,
    S_CALC = 3'd4,
    S_WR   = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // Clamp v into [-2^(sw-1), 2^(sw-1)-1]. The caller truncates the result to
  // sw bits, which is lossless once the value is inside that range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int sw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] r;
    hi = (64'sd1 <<< (sw - 32'sd1)) - 64'sd1;
    lo = -(64'sd1 <<< (sw - 32'sd1));
    if (v > hi) begin
      r = hi;
    end else if (v < lo) begin
      r = lo;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/echo_dpram.sv
// echo_dpram: single-clock simple dual-port RAM holding every channel's delay line.
//   clk    : clock
//   we     : write enable; waddr/wdata written on the rising edge
//   re     : read enable; rdata updates one clock after raddr is presented
//   rdata  : registered read data, holds its value while re is low
// The array has no reset; echo_mc clears it with its INIT sweep.
module echo_dpram #(
  parameter int C_W     = 24,
  parameter int C_WORDS = 32,
  parameter int C_AW    = 5
) (
  input  logic            clk,
  input  logic            we,
  input  logic [C_AW-1:0] waddr,
  input  logic [C_W-1:0]  wdata,
  input  logic            re,
  input  logic [C_AW-1:0] raddr,
  output logic [C_W-1:0]  rdata
);

  logic [C_W-1:0] mem [C_WORDS];
  logic [C_W-1:0] rdata_r;

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // registered read port, one cycle of latency
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/echo_mc.sv
// echo_mc: multichannel feedback echo with a shared delay setting.
// On each Ts strobe taken in IDLE, one frame of C_NCH samples is processed
// serially (RD, WT, CALC, WR per channel); DONE publishes every channel at once.
//   clk, rst_n  : clock, asynchronous active-low reset
//   Ts          : sample strobe (one clk wide)
//   au_in       : packed input samples, channel k at [k*C_SW +: C_SW]
//   delay       : echo delay in samples (0 behaves as 1)
//   fb_gain     : feedback gain, unsigned Q0.C_GW
//   mix_gain    : wet gain, unsigned Q0.C_GW
//   bypass      : dry passthrough (also stores the dry sample in the delay line)
//   ovr_clr     : clears overrun
//   au_out      : packed output samples, held between frames
//   out_valid   : one-cycle pulse when au_out updates
//   busy        : high in every state except IDLE
//   overrun     : sticky, set by a Ts that arrives while busy
module echo_mc
  import echo_pkg::*;
#(
  parameter int  C_SW    = C_SW_DEF,
  parameter int  C_NCH   = C_NCH_DEF,
  parameter int  C_DEPTH = C_DEPTH_DEF,
  parameter int  C_GW    = C_GW_DEF,
  localparam int C_AW    = $clog2(C_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Ts,
  input  logic [C_NCH*C_SW-1:0] au_in,
  input  logic [C_AW-1:0]       delay,
  input  logic [C_GW-1:0]       fb_gain,
  input  logic [C_GW-1:0]       mix_gain,
  input  logic                  bypass,
  input  logic                  ovr_clr,
  output logic [C_NCH*C_SW-1:0] au_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CH_W  = (C_NCH > 1) ? $clog2(C_NCH) : 1;
  localparam int RA_W  = CH_W + C_AW;
  localparam int WORDS = C_NCH * C_DEPTH;
  localparam int PW    = C_SW + C_GW + 1;

  state_t                  state_r;
  state_t                  state_nx;
  logic [RA_W-1:0]         init_cnt_r;
  logic [CH_W-1:0]         ch_r;
  logic [C_AW-1:0]         wptr_r;
  logic [C_AW-1:0]         delay_r;
  logic [C_NCH*C_SW-1:0]   x_r;
  logic [C_GW-1:0]         fb_gain_r;
  logic [C_GW-1:0]         mix_gain_r;
  logic                    bypass_r;
  logic signed [C_SW-1:0]  y_r;
  logic [C_NCH*C_SW-1:0]   out_acc_r;
  logic [C_NCH*C_SW-1:0]   au_out_r;
  logic                    out_valid_r;
  logic                    busy_r;
  logic                    overrun_r;

  logic                    init_last_s;
  logic                    last_ch_s;
  logic                    ovr_set_s;
  logic [C_AW-1:0]         dly_eff_s;
  logic                    ram_we_s;
  logic                    ram_re_s;
  logic [RA_W-1:0]         ram_waddr_s;
  logic [RA_W-1:0]         ram_raddr_s;
  logic [C_SW-1:0]         ram_wdata_s;
  logic [C_SW-1:0]         ram_rdata_s;
  logic signed [C_SW-1:0]  x_s;
  logic signed [C_SW-1:0]  d_s;
  logic signed [PW-1:0]    d_ext_s;
  logic signed [PW-1:0]    fbg_ext_s;
  logic signed [PW-1:0]    mixg_ext_s;
  logic signed [PW-1:0]    fb_s;
  logic signed [PW-1:0]    wet_s;
  logic signed [C_SW-1:0]  y_s;
  logic signed [C_SW-1:0]  out_s;

  assign init_last_s = (init_cnt_r == RA_W'(WORDS - 1));
  assign last_ch_s   = (ch_r == CH_W'(C_NCH - 1));
  assign ovr_set_s   = Ts && (state_r != S_IDLE);

  echo_dpram #(
    .C_W    (C_SW),
    .C_WORDS(WORDS),
    .C_AW   (RA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_s),
    .waddr(ram_waddr_s),
    .wdata(ram_wdata_s),
    .re   (ram_re_s),
    .raddr(ram_raddr_s),
    .rdata(ram_rdata_s)
  );

  // Per-channel arithmetic: gains are unsigned, so they get a zero sign bit
  // before the signed multiply; >>> gives floor rounding on negatives.
  always_comb begin
    dly_eff_s  = (delay_r == {C_AW{1'b0}}) ? C_AW'(1) : delay_r;
    x_s        = x_r[int'(ch_r)*C_SW +: C_SW];
    d_s        = ram_rdata_s;
    d_ext_s    = PW'(d_s);
    fbg_ext_s  = PW'($signed({1'b0, fb_gain_r}));
    mixg_ext_s = PW'($signed({1'b0, mix_gain_r}));
    fb_s       = (d_ext_s * fbg_ext_s) >>> C_GW;
    wet_s      = (d_ext_s * mixg_ext_s) >>> C_GW;
    if (bypass_r) begin
      y_s   = x_s;
      out_s = x_s;
    end else begin
      y_s   = C_SW'(sat(64'(x_s) + 64'(fb_s), C_SW));
      out_s = C_SW'(sat(64'(x_s) + 64'(wet_s), C_SW));
    end
  end

  // Next-state logic and RAM port control. The delay line is addressed as
  // {channel, sample offset}; the offset subtraction wraps modulo C_DEPTH.
  always_comb begin
    state_nx    = state_r;
    ram_we_s    = 1'b0;
    ram_waddr_s = {RA_W{1'b0}};
    ram_wdata_s = {C_SW{1'b0}};
    ram_re_s    = 1'b0;
    ram_raddr_s = {ch_r, wptr_r - dly_eff_s};
    case (state_r)
      S_INIT: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = init_cnt_r;
        if (init_last_s) begin
          state_nx = S_IDLE;
        end else begin
          state_nx = S_INIT;
        end
      end
      S_IDLE: begin
        if (Ts) begin
          state_nx = S_RD;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_RD: begin
        ram_re_s = 1'b1;
        state_nx = S_WT;
      end
      S_WT: begin
        state_nx = S_CALC;
      end
      S_CALC: begin
        state_nx = S_WR;
      end
      S_WR: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = {ch_r, wptr_r};
        ram_wdata_s = y_r;
        if (last_ch_s) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_RD;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_INIT;
      end
    endcase
  end

  // State register; busy is registered from the next state so it tracks state_r exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_INIT;
      busy_r  <= 1'b1;
    end else begin
      state_r <= state_nx;
      busy_r  <= (state_nx != S_IDLE);
    end
  end

  // INIT sweep address; restarts from zero whenever INIT is re-entered via reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_r <= {RA_W{1'b0}};
    end else if (state_r == S_INIT) begin
      init_cnt_r <= init_cnt_r + RA_W'(1);
    end else begin
      init_cnt_r <= {RA_W{1'b0}};
    end
  end

  // Frame capture on an accepted Ts, and channel stepping after each write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r        <= {(C_NCH*C_SW){1'b0}};
      delay_r    <= {C_AW{1'b0}};
      fb_gain_r  <= {C_GW{1'b0}};
      mix_gain_r <= {C_GW{1'b0}};
      bypass_r   <= 1'b0;
      ch_r       <= {CH_W{1'b0}};
    end else if ((state_r == S_IDLE) && Ts) begin
      x_r        <= au_in;
      delay_r    <= delay;
      fb_gain_r  <= fb_gain;
      mix_gain_r <= mix_gain;
      bypass_r   <= bypass;
      ch_r       <= {CH_W{1'b0}};
    end else if ((state_r == S_WR) && !last_ch_s) begin
      ch_r <= ch_r + CH_W'(1);
    end
  end

  // CALC results: y feeds the next WR, out is staged until DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r       <= {C_SW{1'b0}};
      out_acc_r <= {(C_NCH*C_SW){1'b0}};
    end else if (state_r == S_CALC) begin
      y_r                                <= y_s;
      out_acc_r[int'(ch_r)*C_SW +: C_SW] <= out_s;
    end
  end

  // DONE publishes all channels together and advances the write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      au_out_r    <= {(C_NCH*C_SW){1'b0}};
      out_valid_r <= 1'b0;
      wptr_r      <= {C_AW{1'b0}};
    end else begin
      out_valid_r <= (state_r == S_DONE);
      if (state_r == S_DONE) begin
        au_out_r <= out_acc_r;
        wptr_r   <= wptr_r + C_AW'(1);
      end
    end
  end

  // Sticky overrun; a coincident set beats ovr_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (ovr_set_s) begin
      overrun_r <= 1'b1;
    end else if (ovr_clr) begin
      overrun_r <= 1'b0;
    end
  end

  assign au_out    = au_out_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_echo_mc.sv
// tb_echo_mc: self-checking bench for echo_mc (C_SW=24, C_NCH=2, C_DEPTH=16, C_GW=8).
// Table vectors with hand-derived expectations, random frames against a
// frame-level reference model, and directed overrun / mid-frame reset sequences.
module tb_echo_mc;

  localparam int SW    = 24;
  localparam int NCH   = 2;
  localparam int DEPTH = 16;
  localparam int GW    = 8;
  localparam int LAT   = 4 * NCH + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              Ts;
  logic [NCH*SW-1:0] au_in;
  logic [3:0]        delay;
  logic [GW-1:0]     fb_gain;
  logic [GW-1:0]     mix_gain;
  logic              bypass;
  logic              ovr_clr;
  logic [NCH*SW-1:0] au_out;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  always #5 clk = ~clk;

  echo_mc #(.C_SW(SW), .C_NCH(NCH), .C_DEPTH(DEPTH), .C_GW(GW)) dut (
    .clk(clk), .rst_n(rst_n), .Ts(Ts), .au_in(au_in), .delay(delay),
    .fb_gain(fb_gain), .mix_gain(mix_gain), .bypass(bypass), .ovr_clr(ovr_clr),
    .au_out(au_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: one delay line per channel ----------------
  int ring [NCH][DEPTH];
  int m_wptr;

  function automatic int clamp24(input longint v);
    if (v > 64'sd8388607) return 8388607;
    else if (v < -64'sd8388608) return -8388608;
    else return int'(v);
  endfunction

  function automatic longint floor_div256(input longint p);
    if (p >= 0) return p / 256;
    else return -((-p + 255) / 256);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < DEPTH; k++) ring[c][k] = 0;
    m_wptr = 0;
  endtask

  function automatic logic [NCH*SW-1:0] model_frame(input logic [NCH*SW-1:0] xin,
      input int dl, input int fb, input int mix, input bit byp);
    logic [NCH*SW-1:0] res;
    logic [SW-1:0] xs;
    int dd, xv, d, y, o;
    res = '0;
    dd = (dl == 0) ? 1 : dl;
    for (int c = 0; c < NCH; c++) begin
      xs = xin[c*SW +: SW];
      xv = int'($signed(xs));
      d  = ring[c][(m_wptr - dd + DEPTH) % DEPTH];
      if (byp) begin
        y = xv;
        o = xv;
      end else begin
        y = clamp24(longint'(xv) + floor_div256(longint'(d) * fb));
        o = clamp24(longint'(xv) + floor_div256(longint'(d) * mix));
      end
      ring[c][m_wptr] = y;
      res[c*SW +: SW] = 24'(o);
    end
    m_wptr = (m_wptr + 1) % DEPTH;
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    int n;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_au_out", au_out, 48'h0);
    check("rst_busy", busy, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    model_reset();
    rst_n = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("init_busy_cycles", n, 32);
    check("init_au_out", au_out, 48'h0);
  endtask

  // Applies one Ts, scrambles the inputs afterwards (they must be latched),
  // then waits boundedly for out_valid.
  task automatic run_frame(input logic [NCH*SW-1:0] xin, input logic [3:0] dl,
      input logic [GW-1:0] fb, input logic [GW-1:0] mix, input logic byp,
      output logic [NCH*SW-1:0] got, output int lat);
    @(negedge clk);
    au_in = xin; delay = dl; fb_gain = fb; mix_gain = mix; bypass = byp; Ts = 1'b1;
    @(posedge clk);
    #1;
    Ts = 1'b0;
    au_in = {24'($urandom), 24'($urandom)};
    delay = 4'($urandom); fb_gain = 8'($urandom); mix_gain = 8'($urandom);
    bypass = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = au_out;
  endtask

  typedef struct {
    bit          rst;
    logic [23:0] x0;
    logic [3:0]  dl;
    logic [7:0]  fb;
    logic [7:0]  mix;
    logic [23:0] e0;
  } vec_t;

  vec_t tbl [21];
  logic [NCH*SW-1:0] xin, got, exp_v, dummy;
  int lat, n;
  bit byp;

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; Ts = 1'b0; au_in = '0; delay = '0; fb_gain = '0; mix_gain = '0;
    bypass = 1'b0; ovr_clr = 1'b0;
    tbl = '{
      '{1'b1, 24'h100000, 4'd4, 8'd0,   8'd255, 24'h100000},
      '{1'b0, 24'h000000, 4'd4, 8'd0,   8'd255, 24'h000000},
      '{1'b0, 24'h000000, 4'd4, 8'd0,   8'd255, 24'h000000},
      '{1'b0, 24'h000000, 4'd4, 8'd0,   8'd255, 24'h000000},
      '{1'b0, 24'h000000, 4'd4, 8'd0,   8'd255, 24'h0FF000},
      '{1'b0, 24'h000000, 4'd4, 8'd0,   8'd255, 24'h000000},
      '{1'b1, 24'h200000, 4'd2, 8'd128, 8'd128, 24'h200000},
      '{1'b0, 24'h000000, 4'd2, 8'd128, 8'd128, 24'h000000},
      '{1'b0, 24'h000000, 4'd2, 8'd128, 8'd128, 24'h100000},
      '{1'b0, 24'h000000, 4'd2, 8'd128, 8'd128, 24'h000000},
      '{1'b0, 24'h000000, 4'd2, 8'd128, 8'd128, 24'h080000},
      '{1'b0, 24'h000000, 4'd2, 8'd128, 8'd128, 24'h000000},
      '{1'b0, 24'h000000, 4'd2, 8'd128, 8'd128, 24'h040000},
      '{1'b1, 24'h7FFFF0, 4'd1, 8'd255, 8'd255, 24'h7FFFF0},
      '{1'b0, 24'h7FFFF0, 4'd1, 8'd255, 8'd255, 24'h7FFFFF},
      '{1'b0, 24'h7FFFF0, 4'd1, 8'd255, 8'd255, 24'h7FFFFF},
      '{1'b0, 24'h7FFFF0, 4'd1, 8'd255, 8'd255, 24'h7FFFFF},
      '{1'b1, 24'h800010, 4'd1, 8'd255, 8'd255, 24'h800010},
      '{1'b0, 24'h800010, 4'd1, 8'd255, 8'd255, 24'h800000},
      '{1'b0, 24'h800010, 4'd1, 8'd255, 8'd255, 24'h800000},
      '{1'b0, 24'h800010, 4'd1, 8'd255, 8'd255, 24'h800000}
    };
    #2;

    // table vectors (each rst entry starts from a fresh INIT sweep)
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].rst) do_reset();
      xin = {24'h0, tbl[i].x0};
      dummy = model_frame(xin, int'(tbl[i].dl), int'(tbl[i].fb), int'(tbl[i].mix), 1'b0);
      run_frame(xin, tbl[i].dl, tbl[i].fb, tbl[i].mix, 1'b0, got, lat);
      check($sformatf("tbl%0d_lat", i), lat, LAT);
      check($sformatf("tbl%0d_ch0", i), got[23:0], tbl[i].e0);
      check($sformatf("tbl%0d_ch1", i), got[47:24], 24'h0);
    end

    // random frames against the model, including bypass and delay 0
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        xin = {24'($urandom), 24'($urandom)};
      else
        xin = {24'($urandom_range(0, 65535)), 24'(24'hFF0000 | 24'($urandom_range(0, 65535)))};
      delay = 4'($urandom_range(0, 15));
      byp = ($urandom_range(0, 7) == 0);
      fb_gain = 8'($urandom); mix_gain = 8'($urandom);
      exp_v = model_frame(xin, int'(delay), int'(fb_gain), int'(mix_gain), byp);
      run_frame(xin, delay, fb_gain, mix_gain, byp, got, lat);
      check($sformatf("rnd%0d_lat", i), lat, LAT);
      check($sformatf("rnd%0d_out", i), got, exp_v);
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      check($sformatf("rnd%0d_hold", i), au_out, exp_v);
    end

    // Ts pulses 3 cycles apart: one frame only, overrun sticky until cleared
    check("ovr_pre", overrun, 1'b0);
    xin = {24'($urandom), 24'($urandom)};
    exp_v = model_frame(xin, 5, 100, 200, 1'b0);
    @(negedge clk);
    au_in = xin; delay = 4'd5; fb_gain = 8'd100; mix_gain = 8'd200; bypass = 1'b0; Ts = 1'b1;
    @(posedge clk); #1; Ts = 1'b0;
    @(posedge clk);
    @(posedge clk); #1; Ts = 1'b1; au_in = {24'($urandom), 24'($urandom)};
    @(posedge clk); #1; Ts = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        n++;
        got = au_out;
      end
    end
    check("ovr_valid_pulses", n, 1);
    check("ovr_frame_out", got, exp_v);
    check("ovr_set", overrun, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("ovr_sticky", overrun, 1'b1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    check("ovr_cleared", overrun, 1'b0);
    // set and clear in the same cycle: set wins
    xin = {24'h012345, 24'hFEDCBA};
    exp_v = model_frame(xin, 3, 50, 60, 1'b0);
    @(negedge clk);
    au_in = xin; delay = 4'd3; fb_gain = 8'd50; mix_gain = 8'd60; Ts = 1'b1;
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); Ts = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_wins", overrun, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("ovr_frame2_out", au_out, exp_v);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    check("ovr_cleared2", overrun, 1'b0);

    // fill the whole delay line with non-zero data, then reset during CALC
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      xin = {24'h222222, 24'h111111};
      exp_v = model_frame(xin, 1, 0, 0, 1'b0);
      run_frame(xin, 4'd1, 8'd0, 8'd0, 1'b0, got, lat);
      check($sformatf("fill%0d", i), got, exp_v);
    end
    @(negedge clk);
    au_in = {24'h0, 24'h0ABCDE}; delay = 4'd3; Ts = 1'b1;
    @(posedge clk); #1; Ts = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_au_out", au_out, 48'h0);
    check("midrst_busy", busy, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      xin = (i == 1) ? {24'h0, 24'h300000} : 48'h0;
      exp_v = model_frame(xin, 3, 64, 255, 1'b0);
      run_frame(xin, 4'd3, 8'd64, 8'd255, 1'b0, got, lat);
      check($sformatf("post%0d_out", i), got, exp_v);
      if (i == 4) check("post_echo_ch0", got[23:0], 24'h2FD000);
      if (i == 0) check("post_no_stale", got, 48'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
